// File: rtl/m_imem_loader_pkg.sv
// Shared constants for the serial instruction-image loader.
package m_imem_loader_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int IMEM_WORDS       = 4096;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } load_state_t;

  // RX_WAIT parks the receiver after a bad stop bit until the line idles high again.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

endpackage

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, glitch rejection, framing check.
module m_uart_rx
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_rxd,
  output logic [7:0] r_byte,
  output logic       r_valid,
  output logic       r_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rxd_meta;
  logic             rxd_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      r_byte   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      rxd_meta <= w_rxd;
      rxd_sync <= rxd_meta;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rxd_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt    <= '0;
            r_byte <= {rxd_sync, r_byte[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxd_sync) begin
              r_valid <= 1'b1;
              state   <= RX_IDLE;
            end else begin
              r_ferr <= 1'b1;
              state  <= RX_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          if (rxd_sync) state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/m_imem_loader.sv
// Loads a length-prefixed big-endian word image from UART into imem, holding the core in reset.
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADDR_W       = $clog2(IMEM_WORDS)
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rxd,
  output logic              r_we,
  output logic [ADDR_W-1:0] r_addr,
  output logic [31:0]       r_wdata,
  output logic              r_proc_rst,
  output logic              r_done,
  output logic              r_err
);

  localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] REM_ONE   = (ADDR_W + 1)'(1);

  load_state_t     state;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_ferr;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift;
  logic [ADDR_W:0] remaining;
  logic [31:0]     word;

  m_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_rxd   (w_rxd),
    .r_byte  (rx_byte),
    .r_valid (rx_valid),
    .r_ferr  (rx_ferr)
  );

  assign word = {shift, rx_byte};

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state      <= S_HDR;
      byte_cnt   <= '0;
      shift      <= '0;
      remaining  <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_proc_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (rx_ferr) r_err <= 1'b1;
      if (rx_valid && (state == S_HDR || state == S_DATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= word[23:0];
      end
      case (state)
        S_HDR: begin
          if (rx_ferr) begin
            state <= S_ERR;
          end else if (rx_valid && byte_cnt == 2'd3) begin
            if (word == '0) begin
              state      <= S_DONE;
              r_done     <= 1'b1;
              r_proc_rst <= 1'b0;
            end else if ({1'b0, word} > MAX_WORDS) begin
              r_err <= 1'b1;
              state <= S_ERR;
            end else begin
              remaining <= word[ADDR_W:0];
              r_addr    <= '0;
              state     <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_ferr) begin
            state <= S_ERR;
          end else begin
            if (rx_valid && byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= word;
            end
            // The address stops on the last slot so a full-size image cannot wrap it.
            if (r_we) begin
              remaining <= remaining - REM_ONE;
              if (remaining == REM_ONE) begin
                state      <= S_DONE;
                r_done     <= 1'b1;
                r_proc_rst <= 1'b0;
              end else begin
                r_addr <= r_addr + ADDR_W'(1);
              end
            end
          end
        end
        S_DONE, S_ERR: begin
        end
      endcase
    end
  end

endmodule
